// File: rtl/axis_rx_sched.sv
// Round-robin scheduler that lends one AXI-Stream receive port to NREQ requesters,
// one burst at a time, and tags every accepted beat with the current owner.
module axis_rx_sched #(
  parameter int NREQ      = 4,
  parameter int CNT_W     = 5,
  parameter int MAX_BEATS = 16,
  localparam int IDX_W    = $clog2(NREQ)
) (
  input  logic                    axis_aclk,
  input  logic                    axis_areset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*CNT_W-1:0]   req_len,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    err,
  input  logic                    axis_tvalid,
  output logic                    axis_tready,
  input  logic [31:0]             axis_tdata,
  input  logic                    axis_tlast,
  output logic                    out_valid,
  output logic [31:0]             out_data,
  output logic [IDX_W-1:0]        out_owner,
  output logic                    out_last
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               tready_q, tready_d;
  logic               err_q, err_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [CNT_W-1:0]   win_len;
  logic [IDX_W-1:0]   nxt_ptr;
  int                 cand;
  logic               accept;
  logic               at_len;
  logic               last_beat;

  function automatic logic len_bad(input logic [CNT_W-1:0] len);
    return (len == '0) || (int'(len) > MAX_BEATS);
  endfunction

  // Search upward from rr_ptr with wrap-around; first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(rr_ptr_q) + i) % NREQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign win_len   = req_len[win_idx*CNT_W +: CNT_W];
  assign nxt_ptr   = (win_idx == IDX_W'(NREQ-1)) ? '0 : win_idx + IDX_W'(1);

  assign accept    = axis_tvalid & tready_q;
  assign at_len    = (beat_cnt_q == len_q - CNT_W'(1));
  assign last_beat = accept & (at_len | axis_tlast);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    tready_d   = tready_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d    = NREQ'(1) << win_idx;
          owner_d    = win_idx;
          len_d      = win_len;
          rr_ptr_d   = nxt_ptr;
          beat_cnt_d = '0;
          // An illegal length is answered straight away without ever opening tready.
          if (len_bad(win_len)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d    = 1'b0;
            tready_d = 1'b1;
            state_d  = BURST;
          end
        end
      end
      BURST: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (last_beat) begin
            tready_d = 1'b0;
            state_d  = DONE;
            err_d    = axis_tlast ^ at_len;
          end
        end
      end
      DONE: begin
        grant_d    = '0;
        beat_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      tready_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      tready_q   <= tready_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge axis_aclk) begin
    len_q <= len_d;
  end

  assign grant       = grant_q;
  assign done        = (state_q == DONE) ? grant_q : '0;
  assign err         = (state_q == DONE) & err_q;
  assign axis_tready = tready_q;
  assign out_valid   = accept;
  assign out_data    = axis_tdata;
  assign out_owner   = owner_q;
  assign out_last    = last_beat;

endmodule

// File: tb/tb_axis_rx_sched.sv
// Scoreboard bench for axis_rx_sched: expected beats and done events are queued
// as stimulus is set up and retired as the scheduler produces them.
module tb_axis_rx_sched;
  localparam int NREQ  = 4;
  localparam int CNT_W = 5;

  logic                  clk = 1'b0;
  logic                  axis_areset;
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] req_len;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic                  axis_tvalid;
  logic                  axis_tready;
  logic [31:0]           axis_tdata;
  logic                  axis_tlast;
  logic                  out_valid;
  logic [31:0]           out_data;
  logic [1:0]            out_owner;
  logic                  out_last;

  always #5 clk = ~clk;

  axis_rx_sched #(.NREQ(NREQ), .CNT_W(CNT_W), .MAX_BEATS(16)) dut (
    .axis_aclk(clk), .axis_areset(axis_areset), .req(req), .req_len(req_len),
    .grant(grant), .done(done), .err(err), .axis_tvalid(axis_tvalid),
    .axis_tready(axis_tready), .axis_tdata(axis_tdata), .axis_tlast(axis_tlast),
    .out_valid(out_valid), .out_data(out_data), .out_owner(out_owner), .out_last(out_last)
  );

  typedef struct packed {logic [1:0] owner; logic [31:0] data; logic last;} beat_t;
  typedef struct packed {logic [1:0] owner; logic err;} dn_t;

  beat_t           beat_q[$];
  dn_t             done_q[$];
  int              n_chk = 0;
  int              n_pass = 0;
  int              seq = 0;
  int              exp_seq = 0;
  int              src_beat = 0;
  int              pkt_len = 4;
  int              cyc = 0;
  int              tready_cnt = 0;
  int              acc_cnt = 0;
  bit              src_on = 1'b0;
  bit              toggle = 1'b0;
  bit              saw_tready = 1'b0;
  bit              acc_prev = 1'b0;
  bit              last_prev = 1'b0;
  logic [NREQ-1:0] done_prev = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_burst(input int owner, input int nbeats, input bit final_last,
                            input bit with_done, input bit e);
    beat_t b;
    dn_t   d;
    for (int k = 0; k < nbeats; k++) begin
      b.owner = 2'(owner);
      b.data  = 32'hD000_0000 + 32'(exp_seq);
      b.last  = final_last && (k == nbeats - 1);
      beat_q.push_back(b);
      exp_seq++;
    end
    if (with_done) begin
      d.owner = 2'(owner);
      d.err   = e;
      done_q.push_back(d);
    end
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  // Drive just after the rising edge, observe on the falling edge.
  task automatic tick();
    beat_t b;
    dn_t   d;
    @(posedge clk);
    #1;
    if (acc_prev) begin
      seq++;
      src_beat = last_prev ? 0 : src_beat + 1;
    end
    for (int i = 0; i < NREQ; i++)
      if (done_prev[i]) req[i] = 1'b0;
    cyc++;
    axis_tvalid = src_on && (!toggle || (cyc % 2 == 0));
    axis_tdata  = 32'hD000_0000 + 32'(seq);
    axis_tlast  = src_on && (src_beat == pkt_len - 1);
    @(negedge clk);
    acc_prev  = out_valid;
    last_prev = out_last;
    done_prev = done;
    if (axis_tready) begin
      saw_tready = 1'b1;
      tready_cnt++;
    end
    if (out_valid) begin
      acc_cnt++;
      if (beat_q.size() == 0) chk("beat_unexpected", 32'(out_valid), 32'd0);
      else begin
        b = beat_q.pop_front();
        chk("beat_data", out_data, b.data);
        chk("beat_owner", 32'(out_owner), 32'(b.owner));
        chk("beat_last", 32'(out_last), 32'(b.last));
      end
    end
    if (|done) begin
      if (done_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
      else begin
        d = done_q.pop_front();
        chk("done_vec", 32'(done), 32'(4'b0001 << d.owner));
        chk("done_err", 32'(err), 32'(d.err));
      end
    end
  endtask

  task automatic wait_drain(input string tag, input int max);
    for (int k = 0; k < max && (beat_q.size() != 0 || done_q.size() != 0); k++) tick();
    repeat (3) tick();
    chk(tag, 32'(beat_q.size() + done_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    src_on      = 1'b0;
    req         = '0;
    axis_areset = 1'b1;
    tick();
    tick();
    axis_areset = 1'b0;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_tready", 32'(axis_tready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    src_beat = 0;
  endtask

  initial begin
    axis_areset = 1'b1;
    req         = '0;
    req_len     = '0;
    axis_tvalid = 1'b0;
    axis_tdata  = '0;
    axis_tlast  = 1'b0;

    // 1: single burst, tlast exactly on the final counted beat
    do_reset();
    set_len(0, 4);
    pkt_len = 4;
    tready_cnt = 0;
    push_burst(0, 4, 1'b1, 1'b1, 1'b0);
    src_on = 1'b1;
    req = 4'b0001;
    wait_drain("t1_drain", 40);
    chk("t1_tready_cycles", 32'(tready_cnt), 32'd4);

    // 2: all four requesting, served in round-robin order from pointer 0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_len(i, 2);
    pkt_len = 2;
    for (int i = 0; i < NREQ; i++) push_burst(i, 2, 1'b1, 1'b1, 1'b0);
    src_on = 1'b1;
    req = 4'b1111;
    wait_drain("t2_drain", 100);

    // 3: early tlast on beat 3 of an 8-beat request
    set_len(0, 8);
    pkt_len = 3;
    push_burst(0, 3, 1'b1, 1'b1, 1'b1);
    req = 4'b0001;
    wait_drain("t3_drain", 60);

    // 4: zero and oversize lengths complete with err and no tready
    set_len(2, 0);
    saw_tready = 1'b0;
    push_burst(2, 0, 1'b0, 1'b1, 1'b1);
    req = 4'b0100;
    tick();
    chk("t4_len0_latency", 32'(done_q.size()), 32'd0);
    wait_drain("t4_len0_drain", 10);
    set_len(2, 20);
    push_burst(2, 0, 1'b0, 1'b1, 1'b1);
    req = 4'b0100;
    tick();
    chk("t4_len20_latency", 32'(done_q.size()), 32'd0);
    wait_drain("t4_len20_drain", 10);
    chk("t4_no_tready", 32'(saw_tready), 32'd0);

    // 5: reset in the middle of a burst, then clean re-arbitration from pointer 0
    do_reset();
    set_len(2, 6);
    pkt_len = 6;
    push_burst(2, 2, 1'b0, 1'b0, 1'b0);
    src_on = 1'b1;
    req = 4'b0100;
    for (int k = 0; k < 40 && beat_q.size() != 0; k++) tick();
    chk("t5_two_beats", 32'(beat_q.size()), 32'd0);
    src_on = 1'b0;
    tick();
    axis_areset = 1'b1;
    tick();
    axis_areset = 1'b0;
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_tready", 32'(axis_tready), 32'd0);
    src_beat = 0;
    pkt_len = 2;
    set_len(1, 2);
    set_len(3, 2);
    push_burst(1, 2, 1'b1, 1'b1, 1'b0);
    push_burst(3, 2, 1'b1, 1'b1, 1'b0);
    src_on = 1'b1;
    req = 4'b1010;
    wait_drain("t5_drain", 60);

    // 6: tvalid toggling through a 5-beat burst
    set_len(0, 5);
    pkt_len = 5;
    toggle = 1'b1;
    acc_cnt = 0;
    push_burst(0, 5, 1'b1, 1'b1, 1'b0);
    req = 4'b0001;
    wait_drain("t6_drain", 60);
    chk("t6_beat_count", 32'(acc_cnt), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
